// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin.
// One full-subtractor cell plus a borrow flop, LSB first, start/busy/done
// handshake, serial bit stream and parallel result.
// Optional: define SERIAL_SUB_OVF_EN to add the signed overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             diff_bit,
  output logic             diff_bit_valid
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             dbit_q;
  logic             dvalid_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic             dk_d;
  logic             br_d;
  logic             last_d;
  logic [WIDTH-1:0] acc_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers
  always_comb begin
    dk_d   = a_q[0] ^ b_q[0] ^ br_q;
    br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_d = (cnt_q == CNT_W'(WIDTH - 1));
    acc_d  = {dk_d, acc_q[WIDTH-1:1]};
  end

  // Control FSM, operand/result shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      dbit_q   <= 1'b0;
      dvalid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      dvalid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          br_q     <= br_d;
          acc_q    <= acc_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          dbit_q   <= dk_d;
          dvalid_q <= 1'b1;
          if (last_d) begin
            // Final bit: publish the parallel result straight from the
            // shift-in value so diff/bout appear with the done pulse.
            diff_q  <= acc_d;
            bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= br_q ^ br_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign diff           = diff_q;
  assign bout           = bout_q;
  assign diff_bit       = dbit_q;
  assign diff_bit_valid = dvalid_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf            = ovf_q;
`endif

endmodule
